// File: rtl/key_debounce_pkg.sv
// Shared definitions for the DE2 pushbutton conditioning stages: repeat FSM
// encodings and the board-level 50 MHz timing defaults.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } repeat_state_e;

  localparam int BOARD_CLK_HZ        = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int DEF_REPEAT_DELAY    = 25_000_000;  // 500 ms
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;  // 200 ms

  // Counter width is sized to the longest default interval so the default build is legal.
  localparam int DEF_CNT_W = $clog2(DEF_REPEAT_DELAY + 1);

  function automatic bit fitsCnt(input int cycles, input int width);
    return (cycles >= 1) && (longint'(cycles) < (longint'(1) << width));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs (KEY/SW),
// with synchronous active-high reset to a selectable value.
module sync_2ff #(
  parameter int                WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces an active-low pushbutton into a clean level, press/release pulses
// and an auto-repeating tick used as the downstream counter's clock enable.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic tick
);

  if (!fitsCnt(DEBOUNCE_CYCLES, CNT_W)) begin : g_badDebounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits");
  end
  if (!fitsCnt(REPEAT_DELAY, CNT_W)) begin : g_badDelay
    $error("key_debounce: REPEAT_DELAY must be >= 1 and fit in CNT_W bits");
  end
  if (!fitsCnt(REPEAT_PERIOD, CNT_W)) begin : g_badPeriod
    $error("key_debounce: REPEAT_PERIOD must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             keyS;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] dbCnt_q, dbCnt_d;
  repeat_state_e    state_q, state_d;
  logic [CNT_W-1:0] repCnt_q, repCnt_d;
  logic             pressed_q, pressPulse_q, releasePulse_q, tick_q;
  logic             rise, fall, repPulse;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (~key_n),
    .q_o   (keyS)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q <= 1'b0;
      dbCnt_q  <= '0;
    end else begin
      stable_q <= stable_d;
      dbCnt_q  <= dbCnt_d;
    end
  end

  // Any return to the stable level restarts the count, so only an unbroken run flips it.
  always_comb begin
    stable_d = stable_q;
    dbCnt_d  = '0;
    if (keyS != stable_q) begin
      if (dbCnt_q == DB_LAST) begin
        stable_d = keyS;
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end
    end
  end

  // pressed_q lags stable_q by one cycle, so these are the pulses about to be registered.
  assign rise = stable_q & ~pressed_q;
  assign fall = ~stable_q & pressed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RELEASED;
      repCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      repCnt_q <= repCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    repCnt_d = repCnt_q;
    if (REPEAT_EN == 0 || fall) begin
      state_d  = RELEASED;
      repCnt_d = '0;
    end else begin
      case (state_q)
        RELEASED: begin
          if (rise) begin
            state_d  = HOLD_DELAY;
            repCnt_d = '0;
          end
        end
        HOLD_DELAY: begin
          if (repCnt_q == DELAY_LAST) begin
            state_d  = HOLD_REPEAT;
            repCnt_d = '0;
          end else begin
            repCnt_d = repCnt_q + 1'b1;
          end
        end
        HOLD_REPEAT: begin
          if (repCnt_q == PERIOD_LAST) begin
            repCnt_d = '0;
          end else begin
            repCnt_d = repCnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = RELEASED;
          repCnt_d = '0;
        end
      endcase
    end
  end

  // A release arriving in the same cycle as a due repeat wins.
  always_comb begin
    repPulse = 1'b0;
    if (REPEAT_EN != 0 && !fall) begin
      case (state_q)
        HOLD_DELAY:  repPulse = (repCnt_q == DELAY_LAST);
        HOLD_REPEAT: repPulse = (repCnt_q == PERIOD_LAST);
        default:     repPulse = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pressed_q      <= 1'b0;
      pressPulse_q   <= 1'b0;
      releasePulse_q <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      pressed_q      <= stable_q;
      pressPulse_q   <= rise;
      releasePulse_q <= fall;
      tick_q         <= rise | repPulse;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = pressPulse_q;
  assign release_pulse = releasePulse_q;
  assign tick          = tick_q;

endmodule
